fetch_next_pc: RTL and testbench

- Instruction-fetch stage placed directly upstream of the main `Control` decoder in the single-cycle MIPS core.
- Holds the PC and requests instructions from instruction memory with a ready handshake.
- Latches each fetched word and presents `op` (inst[31:26]) to `Control`.
- Computes the next PC from `Control`'s `Jump`/`Branch` and the ALU `zero` flag once the datapath has executed the instruction.

---
 rtl/fetch_next_pc.sv | 115 +++++++++++
 tb/tb_fetch_next_pc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_next_pc.sv
// Instruction-fetch stage for the single-cycle MIPS core: holds the PC, fetches via a
// ready handshake, presents the latched opcode to Control and resolves jump/branch.
module fetch_next_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    output logic             imem_req,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    input  logic             jump,
    input  logic             branch,
    input  logic             alu_zero,
    input  logic             stall,
    output logic [31:0]      inst,
    output logic [5:0]       op,
    output logic             inst_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetchState_t;

    localparam logic [31:0]      PC_START = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    fetchState_t state;
    fetchState_t stateNext;
    logic        loadInst;
    logic        advance;
    logic [31:0] jumpTarget;
    logic [31:0] branchOffset;
    logic [31:0] branchTarget;
    logic [31:0] nextRaw;
    logic [31:0] nextPc;

    // Target computation is purely from registered state (pc, inst) plus Control inputs.
    assign pc_plus4     = pc + 32'd4;
    assign jumpTarget   = {pc_plus4[31:28], inst[25:0], 2'b00};
    assign branchOffset = {{14{inst[15]}}, inst[15:0], 2'b00};
    assign branchTarget = pc_plus4 + branchOffset;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        nextRaw = pc_plus4;
        if (jump) begin
            nextRaw = jumpTarget;
        end else if (branch && alu_zero) begin
            nextRaw = branchTarget;
        end
    end

    assign nextPc = nextRaw & 32'hFFFF_FFFC;

    always_comb begin
        stateNext  = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        loadInst   = 1'b0;
        advance    = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    loadInst  = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                inst_valid = 1'b1;
                if (!stall) begin
                    advance   = 1'b1;
                    stateNext = FETCH;
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= PC_START;
            inst    <= 32'h0000_0000;
            retired <= '0;
        end else begin
            if (loadInst) begin
                inst <= imem_rdata;
            end
            if (advance) begin
                pc      <= nextPc;
                retired <= retired + CNT_ONE;
            end
        end
    end

    // op comes only from the instruction register, never straight from memory.
    assign op        = inst[31:26];
    assign imem_addr = pc;

endmodule

// File: tb/tb_fetch_next_pc.sv
// Directed self-checking bench for fetch_next_pc; a second instance with a high reset
// PC and a narrow counter covers the upper-region jump and the retired-count wrap.
module tb_fetch_next_pc;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        jump;
    logic        branch;
    logic        alu_zero;
    logic        stall;

    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] inst;
    logic [5:0]  op;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [15:0] retired;

    logic [31:0] hiImemAddr;
    logic        hiImemReq;
    logic [31:0] hiInst;
    logic [5:0]  hiOp;
    logic        hiInstValid;
    logic [31:0] hiPc;
    logic [31:0] hiPcPlus4;
    logic [1:0]  hiRetired;

    int checks = 0;
    int errors = 0;

    fetch_next_pc #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .jump(jump), .branch(branch), .alu_zero(alu_zero), .stall(stall),
        .inst(inst), .op(op), .inst_valid(inst_valid),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
    );

    fetch_next_pc #(.RESET_PC(32'h4000_0020), .CNT_W(2)) dutHi (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(hiImemAddr), .imem_req(hiImemReq),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .jump(jump), .branch(branch), .alu_zero(alu_zero), .stall(stall),
        .inst(hiInst), .op(hiOp), .inst_valid(hiInstValid),
        .pc(hiPc), .pc_plus4(hiPcPlus4), .retired(hiRetired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_rdata = 32'h0;
        imem_ready = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_zero   = 1'b0;
        stall      = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_pc",        pc,                  32'h0);
        chk("rst_inst",      inst,                32'h0);
        chk("rst_op",        {26'b0, op},         32'h0);
        chk("rst_valid",     {31'b0, inst_valid}, 32'h0);
        chk("rst_req",       {31'b0, imem_req},   32'h1);
        chk("rst_retired",   {16'b0, retired},    32'h0);
        chk("rst_hi_pc",     hiPc,                32'h4000_0020);
        rst_n = 1'b1;

        // Memory not ready for 3 cycles at pc=0
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req",   {31'b0, imem_req},   32'h1);
            chk("wait_valid", {31'b0, inst_valid}, 32'h0);
            chk("wait_addr",  imem_addr,           32'h0);
        end

        // lw stream, ready always high
        imem_ready = 1'b1;
        imem_rdata = 32'h8C01_0004;
        tick();
        chk("lw_valid",   {31'b0, inst_valid}, 32'h1);
        chk("lw_op",      {26'b0, op},         32'h23);
        chk("lw_req",     {31'b0, imem_req},   32'h0);
        chk("lw_pc0",     pc,                  32'h0);
        tick();
        chk("lw_pc4",     pc,                  32'h4);
        chk("lw_addr4",   imem_addr,           32'h4);
        chk("lw_plus4",   pc_plus4,            32'h8);
        chk("lw_ret1",    {16'b0, retired},    32'h1);
        chk("lw_fetch",   {31'b0, imem_req},   32'h1);
        tick();
        tick();
        chk("lw_pc8",     pc,                  32'h8);
        chk("lw_ret2",    {16'b0, retired},    32'h2);

        // Jump from 8 to 0x10
        imem_rdata = 32'h0800_0004;
        tick();
        chk("j_op",       {26'b0, op},         32'h02);
        jump = 1'b1;
        tick();
        jump = 1'b0;
        chk("j_pc",       pc,                  32'h10);

        // beq offset -2 taken at 0x10
        imem_rdata = 32'h1000_FFFE;
        tick();
        chk("beq_op",     {26'b0, op},         32'h04);
        branch   = 1'b1;
        alu_zero = 1'b1;
        tick();
        branch   = 1'b0;
        alu_zero = 1'b0;
        chk("beq_taken",  pc,                  32'h0C);

        imem_rdata = 32'h0000_0000;
        tick();
        tick();
        chk("nop_pc",     pc,                  32'h10);

        // beq not taken at 0x10
        imem_rdata = 32'h1000_FFFE;
        tick();
        branch = 1'b1;
        tick();
        branch = 1'b0;
        chk("beq_nt",     pc,                  32'h14);
        chk("beq_ret",    {16'b0, retired},    32'h6);

        // Stall in ISSUE; jump asserted meanwhile must be ignored
        imem_rdata = 32'h8C01_0004;
        tick();
        stall = 1'b1;
        jump  = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_pc",    pc,                  32'h14);
            chk("stall_inst",  inst,                32'h8C01_0004);
            chk("stall_op",    {26'b0, op},         32'h23);
            chk("stall_ret",   {16'b0, retired},    32'h6);
            chk("stall_valid", {31'b0, inst_valid}, 32'h1);
        end
        stall = 1'b0;
        jump  = 1'b0;
        imem_rdata = 32'h8C01_0004;
        tick();
        chk("unstall_pc",  pc,                  32'h18);
        chk("unstall_ret", {16'b0, retired},    32'h7);
        tick();
        chk("single_upd",  pc,                  32'h18);

        // Advance to ISSUE at 0x20, then reset mid-issue
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_pc",    pc,                  32'h20);
        chk("pre_rst_valid", {31'b0, inst_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_pc",    pc,                  32'h0);
        chk("async_ret",   {16'b0, retired},    32'h0);
        chk("async_valid", {31'b0, inst_valid}, 32'h0);
        chk("async_req",   {31'b0, imem_req},   32'h1);
        chk("async_hi_pc", hiPc,                32'h4000_0020);
        tick();
        rst_n = 1'b1;

        // Jump with branch+zero also high: jump wins
        imem_rdata = 32'h0800_0040;
        tick();
        jump     = 1'b1;
        branch   = 1'b1;
        alu_zero = 1'b1;
        tick();
        jump     = 1'b0;
        branch   = 1'b0;
        alu_zero = 1'b0;
        chk("jprio_pc",    pc,                  32'h100);
        chk("jprio_hi_pc", hiPc,                32'h4000_0100);

        // Negative branch wrapping below zero: 0x104 - 0x108
        imem_rdata = 32'h1000_FFBE;
        tick();
        branch   = 1'b1;
        alu_zero = 1'b1;
        tick();
        branch   = 1'b0;
        alu_zero = 1'b0;
        chk("neg_wrap_pc", pc,                  32'hFFFF_FFFC);
        chk("neg_wrap_p4", pc_plus4,            32'h0);
        chk("hi_neg_pc",   hiPc,                32'h3FFF_FFFC);

        // Sequential wrap 0xFFFF_FFFC -> 0
        imem_rdata = 32'h0000_0000;
        tick();
        tick();
        chk("seq_wrap_pc", pc,                  32'h0);
        chk("hi_ret3",     {30'b0, hiRetired},  32'h3);

        // Narrow counter wraps from all-ones to zero
        tick();
        tick();
        chk("ret_main",    {16'b0, retired},    32'h4);
        chk("hi_ret_wrap", {30'b0, hiRetired},  32'h0);
        chk("hi_pc_end",   hiPc,                32'h4000_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
